// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the sequential adder/subtractor: state encoding,
// slice-count derivation and the counter-width macro.
`ifndef SEQ_ADDSUB_PKG_SV
`define SEQ_ADDSUB_PKG_SV

// Width of a counter able to index x items (never narrower than 1 bit).
`define SEQ_ADDSUB_LOG2(x) (((x) <= 1) ? 1 : $clog2(x))

package seq_addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int unsigned nslice(input int unsigned width, input int unsigned slice);
      return width / slice;
   endfunction

endpackage

`endif

// File: rtl/seq_addsub_n_adder_slice.sv
// Combinational SLICE-bit adder; also exposes the carry into its MSB so the
// top slice can derive signed overflow.
module adder_slice #(
   parameter int unsigned SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   logic [SLICE:0] total;

   always_comb begin
      total = {1'b0, a} + {1'b0, b} + (SLICE+1)'(cin);
      sum   = total[SLICE-1:0];
      cout  = total[SLICE];
      // sum bit = a ^ b ^ carry-in, so the MSB's carry-in falls out directly
      cmsb  = total[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
   end

endmodule

// File: rtl/seq_addsub_n.sv
// Multi-cycle WIDTH-bit adder/subtractor, SLICE bits per clock, LSB first.
// Optional unsigned saturation on the final result: define SEQ_ADDSUB_SAT_EN.
module seq_addsub_n
   import seq_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cf,
   output logic             of,
   output logic             zf,
   output logic             sf,
   output logic             busy
);

   localparam int unsigned NSLICE = nslice(WIDTH, SLICE);
   localparam int unsigned KW     = `SEQ_ADDSUB_LOG2(NSLICE);

   state_t            state, state_nxt;
   logic [KW-1:0]     k, k_nxt;
   logic [WIDTH-1:0]  a_sh, a_sh_nxt;
   logic [WIDTH-1:0]  b_sh, b_sh_nxt;
   logic              carry, carry_nxt;
   logic              sub_q, sub_nxt;
   logic [WIDTH-1:0]  s_nxt, s_fin;
   logic              cf_nxt, of_nxt, zf_nxt, sf_nxt, cf_raw;
   logic              in_ready_nxt, out_valid_nxt, busy_nxt;

   logic [SLICE-1:0]  slice_sum;
   logic              slice_cout, slice_cmsb;

   // Operands are shifted right each CALC cycle so the active slice is always the LSBs.
   adder_slice #(.SLICE(SLICE)) u_slice (
      .a    (a_sh[SLICE-1:0]),
      .b    (b_sh[SLICE-1:0]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout),
      .cmsb (slice_cmsb)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         k         <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         carry     <= 1'b0;
         sub_q     <= 1'b0;
         s         <= '0;
         cf        <= 1'b0;
         of        <= 1'b0;
         zf        <= 1'b0;
         sf        <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         k         <= k_nxt;
         a_sh      <= a_sh_nxt;
         b_sh      <= b_sh_nxt;
         carry     <= carry_nxt;
         sub_q     <= sub_nxt;
         s         <= s_nxt;
         cf        <= cf_nxt;
         of        <= of_nxt;
         zf        <= zf_nxt;
         sf        <= sf_nxt;
         in_ready  <= in_ready_nxt;
         out_valid <= out_valid_nxt;
         busy      <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      a_sh_nxt  = a_sh;
      b_sh_nxt  = b_sh;
      carry_nxt = carry;
      sub_nxt   = sub_q;
      s_nxt     = s;
      cf_nxt    = cf;
      of_nxt    = of;
      zf_nxt    = zf;
      sf_nxt    = sf;
      cf_raw    = slice_cout ^ sub_q;
      s_fin     = {slice_sum, s[WIDTH-1:SLICE]};

      unique case (state)
         ST_IDLE: begin
            if (in_valid) begin
               // a - b - cin == a + ~b + ~cin
               a_sh_nxt  = a;
               b_sh_nxt  = sub ? ~b : b;
               carry_nxt = cin ^ sub;
               sub_nxt   = sub;
               k_nxt     = '0;
               state_nxt = ST_CALC;
            end
         end
         ST_CALC: begin
            a_sh_nxt  = a_sh >> SLICE;
            b_sh_nxt  = b_sh >> SLICE;
            carry_nxt = slice_cout;
            s_nxt     = s_fin;
            k_nxt     = k + KW'(1);
            if (k == KW'(NSLICE - 1)) begin
`ifdef SEQ_ADDSUB_SAT_EN
               if (cf_raw) s_fin = sub_q ? '0 : '1;
               s_nxt = s_fin;
`endif
               cf_nxt    = cf_raw;
               of_nxt    = slice_cmsb ^ slice_cout;
               zf_nxt    = (s_fin == '0);
               sf_nxt    = s_fin[WIDTH-1];
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      in_ready_nxt  = (state_nxt == ST_IDLE);
      busy_nxt      = (state_nxt == ST_CALC);
      out_valid_nxt = (state_nxt == ST_DONE);
   end

endmodule

// File: tb/tb_seq_addsub_n.sv
// Directed and randomised bench for seq_addsub_n at WIDTH=8 and WIDTH=32.
module tb_seq_addsub_n;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       iv8 = 0, ir8, cin8 = 0, sub8 = 0, ov8, ordy8 = 0, cf8, of8, zf8, sf8, busy8;
   logic [7:0] a8 = 0, b8 = 0, s8;
   logic        iv32 = 0, ir32, cin32 = 0, sub32 = 0, ov32, ordy32 = 0, cf32, of32, zf32, sf32, busy32;
   logic [31:0] a32 = 0, b32 = 0, s32;

   int n_cmp  = 0;
   int n_fail = 0;

   seq_addsub_n #(.WIDTH(8), .SLICE(4)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(ordy8), .s(s8),
      .cf(cf8), .of(of8), .zf(zf8), .sf(sf8), .busy(busy8));

   seq_addsub_n #(.WIDTH(32), .SLICE(4)) u32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(ordy32), .s(s32),
      .cf(cf32), .of(of32), .zf(zf32), .sf(sf32), .busy(busy32));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Latency counts clock edges from the accept edge (inclusive) to the edge raising out_valid.
   task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts,
                      input logic [7:0] es, input logic ecf, input logic eof, input logic ezf,
                      input logic esf, input string tag);
      int lat;
      @(negedge clk);
      a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; iv8 = 1;
      check({tag, "_ready"}, 32'(ir8), 32'd1);
      @(posedge clk);
      @(negedge clk);
      iv8 = 0;
      lat = 1;
      while (!ov8 && lat < 64) begin @(negedge clk); lat++; end
      check({tag, "_valid"}, 32'(ov8), 32'd1);
      check({tag, "_lat"}, 32'(lat), 32'd3);
      check({tag, "_s"},  32'(s8),  32'(es));
      check({tag, "_cf"}, 32'(cf8), 32'(ecf));
      check({tag, "_of"}, 32'(of8), 32'(eof));
      check({tag, "_zf"}, 32'(zf8), 32'(ezf));
      check({tag, "_sf"}, 32'(sf8), 32'(esf));
      ordy8 = 1;
      @(posedge clk);
      @(negedge clk);
      ordy8 = 0;
      check({tag, "_drop"}, 32'(ov8), 32'd0);
   endtask

   task automatic start32(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                          input logic ts, input string tag);
      int n;
      @(negedge clk);
      a32 = ta; b32 = tb; cin32 = tc; sub32 = ts; iv32 = 1;
      n = 0;
      while (!ir32 && n < 64) begin @(negedge clk); n++; end
      check({tag, "_ready"}, 32'(ir32), 32'd1);
      @(posedge clk);
      @(negedge clk);
      iv32 = 0;
   endtask

   task automatic wait32(input string tag, output int lat);
      lat = 1;
      while (!ov32 && lat < 64) begin @(negedge clk); lat++; end
      check({tag, "_valid"}, 32'(ov32), 32'd1);
   endtask

   task automatic res32(input string tag, input logic [31:0] es, input logic ecf,
                        input logic eof, input logic ezf, input logic esf);
      check({tag, "_s"},  s32,         es);
      check({tag, "_cf"}, 32'(cf32), 32'(ecf));
      check({tag, "_of"}, 32'(of32), 32'(eof));
      check({tag, "_zf"}, 32'(zf32), 32'(ezf));
      check({tag, "_sf"}, 32'(sf32), 32'(esf));
   endtask

   task automatic ack32(input string tag);
      ordy32 = 1;
      @(posedge clk);
      @(negedge clk);
      ordy32 = 0;
      check({tag, "_drop"}, 32'(ov32), 32'd0);
   endtask

   // Independent reference: arithmetic on full integers, flags from operand signs.
   task automatic model32(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                          input logic ts, output logic [31:0] rs, output logic rcf,
                          output logic rof, output logic rzf, output logic rsf);
      logic [32:0] wide;
      if (!ts) begin
         wide = {1'b0, ta} + {1'b0, tb} + 33'(tc);
         rs   = wide[31:0];
         rcf  = wide[32];
         rof  = (ta[31] == tb[31]) && (rs[31] != ta[31]);
      end else begin
         rs   = ta - tb - 32'(tc);
         rcf  = ({1'b0, ta} < ({1'b0, tb} + 33'(tc)));
         rof  = (ta[31] != tb[31]) && (rs[31] != ta[31]);
      end
`ifdef SEQ_ADDSUB_SAT_EN
      if (rcf) rs = ts ? 32'h0 : 32'hFFFF_FFFF;
`endif
      rzf = (rs == 32'h0);
      rsf = rs[31];
   endtask

   initial begin
      int lat;
      logic [31:0] hold, ra, rb, es;
      logic rc, rsub, ecf, eof, ezf, esf;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(ir32), 32'd1);
      check("rst_out_valid", 32'(ov32), 32'd0);
      check("rst_s", s32, 32'd0);
      check("rst_flags", {28'd0, cf32, of32, zf32, sf32}, 32'd0);
      check("rst_busy", 32'(busy32), 32'd0);
      check("rst_busy8", 32'(busy8), 32'd0);
      rst_n = 1;

      // 8-bit directed
      op8(8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, "add8");
`ifdef SEQ_ADDSUB_SAT_EN
      op8(8'h10, 8'h20, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "sub8");
`else
      op8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, "sub8");
`endif
      op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, "subov8");

      // 32-bit carry ripples through every slice
      start32(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, "add32");
      check("add32_busy", 32'(busy32), 32'd1);
      wait32("add32", lat);
      check("add32_lat", 32'(lat), 32'd9);
`ifdef SEQ_ADDSUB_SAT_EN
      res32("add32", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
`else
      res32("add32", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
      ack32("add32");

      // Backpressure with a pending new operand
      start32(32'd5, 32'd3, 1'b1, 1'b1, "bp1");
      wait32("bp1", lat);
      res32("bp1", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      hold = s32;
      a32 = 32'h7FFF_FFFF; b32 = 32'd1; cin32 = 0; sub32 = 0; iv32 = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_s", s32, hold);
         check("bp_hold_valid", 32'(ov32), 32'd1);
         check("bp_hold_ready", 32'(ir32), 32'd0);
      end
      ordy32 = 1;
      @(posedge clk);
      @(negedge clk);
      ordy32 = 0;
      check("bp_drop", 32'(ov32), 32'd0);
      check("bp_idle_ready", 32'(ir32), 32'd1);
      @(posedge clk);
      @(negedge clk);
      iv32 = 0;
      check("bp2_accepted", 32'(busy32), 32'd1);
      check("bp2_not_ready", 32'(ir32), 32'd0);
      wait32("bp2", lat);
      check("bp2_lat", 32'(lat), 32'd9);
      res32("bp2", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
      ack32("bp2");

      // Reset mid-CALC at k=3
      start32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "rstmid");
      repeat (3) @(negedge clk);
      check("rstmid_busy", 32'(busy32), 32'd1);
      rst_n = 0;
      @(negedge clk);
      check("rstmid_valid", 32'(ov32), 32'd0);
      check("rstmid_s", s32, 32'd0);
      check("rstmid_ready", 32'(ir32), 32'd1);
      check("rstmid_busy0", 32'(busy32), 32'd0);
      rst_n = 1;
      start32(32'd1, 32'd1, 1'b0, 1'b0, "post");
      wait32("post", lat);
      res32("post", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      ack32("post");

      // Randomised back-to-back against the reference model
      for (int i = 0; i < 16; i++) begin
         ra = $urandom; rb = $urandom;
         rc = 1'($urandom_range(1)); rsub = 1'($urandom_range(1));
         if (i == 0) begin ra = 32'h0; rb = 32'h0; rc = 1'b0; rsub = 1'b1; end
         model32(ra, rb, rc, rsub, es, ecf, eof, ezf, esf);
         start32(ra, rb, rc, rsub, "rnd");
         wait32("rnd", lat);
         res32("rnd", es, ecf, eof, ezf, esf);
         ack32("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
